// File: rtl/morra_match_driver.sv
// -----------------------------------------------------------------------------
// morra_match_driver
//   Match-level initiator for the Morracinese game core. The host starts a
//   match, streams move pairs through a small valid/ready FIFO and receives a
//   one-cycle done pulse with the final result plus a saturating scoreboard.
//
// Ports
//   clk, reset                 system clock (rising edge), async active-high reset
//   start, cfg_max[3:0]        begin/abort a match; manche limit code for the core
//   mv_valid/mv_ready          move-pair handshake, mv_p1/mv_p2 the pair (2b each)
//   core_primo/secondo/reset   registered pins into the core
//   core_manche/core_partita   Mealy responses from the core
//   busy, done, result         match status (done is a single-cycle pulse)
//   wins_p1, wins_p2, ties,
//   invalid_cnt, played        saturating scoreboard counters (CNT_W bits)
// -----------------------------------------------------------------------------
module morra_match_driver #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cfg_max,
    input  logic             mv_valid,
    output logic             mv_ready,
    input  logic [1:0]       mv_p1,
    input  logic [1:0]       mv_p2,
    output logic [1:0]       core_primo,
    output logic [1:0]       core_secondo,
    output logic             core_reset,
    input  logic [1:0]       core_manche,
    input  logic [1:0]       core_partita,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] wins_p1,
    output logic [CNT_W-1:0] wins_p2,
    output logic [CNT_W-1:0] ties,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic [CNT_W-1:0] played
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONFIG, S_PLAY} state_t;

    state_t        state, state_d;
    logic [1:0]    mem_p1 [FIFO_DEPTH];
    logic [1:0]    mem_p2 [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          present;
    logic          empty, full;
    logic          sample, match_end, pop, push, flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign busy     = (state != S_IDLE);
    assign mv_ready = !full && busy;

    // start has priority over everything: it suppresses scoring, the end of
    // match and the pop, so an abort never leaks a done pulse.
    assign sample    = (state == S_PLAY) && present && !start;
    assign match_end = sample && (core_partita != 2'b00);
    assign pop       = (state == S_PLAY) && !start && !match_end && !empty;
    assign flush     = start || match_end;
    assign push      = mv_valid && mv_ready && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (start) state_d = S_CONFIG;
            S_CONFIG: state_d = start ? S_CONFIG : S_PLAY;
            S_PLAY: begin
                if (start)          state_d = S_CONFIG;
                else if (match_end) state_d = S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_p1[wr_ptr[AW-1:0]] <= mv_p1;
            mem_p2[wr_ptr[AW-1:0]] <= mv_p2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Core pins: the CONFIG cycle carries cfg_max on the move pins while the
    // core is held in reset; in PLAY the pins show the popped pair or 00/00.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_primo   <= '0;
            core_secondo <= '0;
            core_reset   <= 1'b1;
            present      <= 1'b0;
        end else if (start) begin
            core_primo   <= cfg_max[3:2];
            core_secondo <= cfg_max[1:0];
            core_reset   <= 1'b1;
            present      <= 1'b0;
        end else if (state == S_PLAY && pop) begin
            core_primo   <= mem_p1[rd_ptr[AW-1:0]];
            core_secondo <= mem_p2[rd_ptr[AW-1:0]];
            core_reset   <= 1'b0;
            present      <= 1'b1;
        end else begin
            core_primo   <= '0;
            core_secondo <= '0;
            core_reset   <= (state == S_IDLE) || match_end;
            present      <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wins_p1     <= '0;
            wins_p2     <= '0;
            ties        <= '0;
            invalid_cnt <= '0;
            played      <= '0;
            result      <= '0;
            done        <= 1'b0;
        end else begin
            done <= match_end;
            if (start) begin
                wins_p1     <= '0;
                wins_p2     <= '0;
                ties        <= '0;
                invalid_cnt <= '0;
                played      <= '0;
                result      <= '0;
            end else begin
                if (sample) begin
                    case (core_manche)
                        2'b01:   wins_p1     <= sat_inc(wins_p1);
                        2'b10:   wins_p2     <= sat_inc(wins_p2);
                        2'b11:   ties        <= sat_inc(ties);
                        default: invalid_cnt <= sat_inc(invalid_cnt);
                    endcase
                    if (core_manche != 2'b00) played <= sat_inc(played);
                end
                if (match_end) result <= core_partita;
            end
        end
    end

endmodule

// File: tb/tb_morra_match_driver.sv
// -----------------------------------------------------------------------------
// tb_morra_match_driver
//   Drives morra_match_driver with directed and randomized matches against a
//   simple Morra core stub. Expected scoreboards are computed from the list of
//   pairs the host handed over and the game rules.
// -----------------------------------------------------------------------------
module tb_morra_match_driver;

    localparam int CNT_W = 5;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       cfg_max = '0;
    logic             mv_valid = 1'b0;
    logic             mv_ready;
    logic [1:0]       mv_p1 = '0, mv_p2 = '0;
    logic [1:0]       core_primo, core_secondo;
    logic             core_reset;
    logic [1:0]       core_manche, core_partita;
    logic             busy, done;
    logic [1:0]       result;
    logic [CNT_W-1:0] wins_p1, wins_p2, ties, invalid_cnt, played;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    morra_match_driver #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_max(cfg_max),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_p1(mv_p1), .mv_p2(mv_p2),
        .core_primo(core_primo), .core_secondo(core_secondo), .core_reset(core_reset),
        .core_manche(core_manche), .core_partita(core_partita),
        .busy(busy), .done(done), .result(result),
        .wins_p1(wins_p1), .wins_p2(wins_p2), .ties(ties),
        .invalid_cnt(invalid_cnt), .played(played)
    );

    // Morra rules: sasso(01) beats forbice(11), carta(10) beats sasso,
    // forbice beats carta; a missing move makes the manche invalid.
    function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
        if (a == 2'd0 || b == 2'd0) return 2'b00;
        if (a == b) return 2'b11;
        if ((a == 2'd1 && b == 2'd3) || (a == 2'd2 && b == 2'd1) || (a == 2'd3 && b == 2'd2))
            return 2'b01;
        return 2'b10;
    endfunction

    // Core stub: Mealy manche from the pins, partita raised on pair end_at.
    int         end_at  = 0;
    logic [1:0] end_val = 2'b01;
    int         pair_seen;
    logic       pins_nz;

    assign pins_nz = (core_primo != 2'd0) || (core_secondo != 2'd0);

    always @(posedge clk or posedge reset) begin
        if (reset)           pair_seen <= 0;
        else if (core_reset) pair_seen <= 0;
        else if (pins_nz)    pair_seen <= pair_seen + 1;
    end

    always_comb begin
        core_manche  = core_reset ? 2'b00 : rps(core_primo, core_secondo);
        core_partita = 2'b00;
        if (!core_reset && pins_nz && end_at != 0 && pair_seen == end_at - 1)
            core_partita = end_val;
    end

    // Monitor: every pair presented to the core, with its cycle stamp.
    int         cyc = 0;
    logic [1:0] seen_p1[$], seen_p2[$];
    int         seen_cyc[$];
    int         done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && !core_reset && pins_nz) begin
            seen_p1.push_back(core_primo);
            seen_p2.push_back(core_secondo);
            seen_cyc.push_back(cyc);
        end
        if (done) done_cnt = done_cnt + 1;
    end

    // Host-side stimulus and reference scoreboard.
    logic [1:0] tx_p1[64], tx_p2[64];
    int acc_n;
    int e_w1, e_w2, e_t, e_inv, e_pl;

    task automatic model(input int n);
        logic [1:0] m;
        e_w1 = 0; e_w2 = 0; e_t = 0; e_inv = 0; e_pl = 0;
        for (int i = 0; i < n; i++) begin
            m = rps(tx_p1[i], tx_p2[i]);
            if (m == 2'b01) e_w1++;
            else if (m == 2'b10) e_w2++;
            else if (m == 2'b11) e_t++;
            else e_inv++;
            if (m != 2'b00) e_pl++;
        end
        if (e_w1 > CMAX) e_w1 = CMAX;
        if (e_w2 > CMAX) e_w2 = CMAX;
        if (e_t > CMAX) e_t = CMAX;
        if (e_inv > CMAX) e_inv = CMAX;
        if (e_pl > CMAX) e_pl = CMAX;
    endtask

    task automatic do_start(input logic [3:0] c);
        @(negedge clk);
        start = 1'b1;
        cfg_max = c;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input int n, input bit gaps);
        int  guard;
        bit  ok;
        acc_n = 0;
        guard = 0;
        while (acc_n < n && guard < 400) begin
            @(negedge clk);
            if (!busy) break;
            mv_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            mv_p1 = tx_p1[acc_n];
            mv_p2 = tx_p2[acc_n];
            ok = mv_valid && mv_ready;
            @(posedge clk);
            if (ok) acc_n++;
            guard++;
        end
        @(negedge clk);
        mv_valid = 1'b0;
    endtask

    task automatic check_score(input string tag);
        total++;
        if (int'(wins_p1) !== e_w1 || int'(wins_p2) !== e_w2 || int'(ties) !== e_t ||
            int'(invalid_cnt) !== e_inv || int'(played) !== e_pl) begin
            bad++;
            $display("FAIL %s score got w1=%0d w2=%0d t=%0d inv=%0d pl=%0d exp w1=%0d w2=%0d t=%0d inv=%0d pl=%0d",
                     tag, wins_p1, wins_p2, ties, invalid_cnt, played, e_w1, e_w2, e_t, e_inv, e_pl);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({core_reset, core_primo, core_secondo} !== 5'b1_00_00) begin
            bad++; $display("FAIL reset_pins got %b exp 10000", {core_reset, core_primo, core_secondo});
        end
        total++;
        if ({mv_ready, busy, done, result} !== 5'b0) begin
            bad++; $display("FAIL reset_status got %b exp 00000", {mv_ready, busy, done, result});
        end
        model(0);
        check_score("reset");
        reset = 1'b0;
        mv_valid = 1'b1;
        @(negedge clk);
        total++;
        if (mv_ready !== 1'b0) begin
            bad++; $display("FAIL idle_ready got %b exp 0", mv_ready);
        end
        mv_valid = 1'b0;
    endtask

    task automatic test_config(input logic [3:0] c);
        do_start(c);
        total++;
        if ({core_reset, core_primo, core_secondo} !== {1'b1, c}) begin
            bad++; $display("FAIL config_pins got %b exp %b", {core_reset, core_primo, core_secondo}, {1'b1, c});
        end
        total++;
        if ({busy, mv_ready, done} !== 3'b110) begin
            bad++; $display("FAIL config_status got %b exp 110", {busy, mv_ready, done});
        end
        @(negedge clk);
        total++;
        if ({core_reset, core_primo, core_secondo, busy, mv_ready} !== 7'b0_00_00_11) begin
            bad++; $display("FAIL play_entry got %b exp 0000011",
                            {core_reset, core_primo, core_secondo, busy, mv_ready});
        end
    endtask

    task automatic test_latency;
        end_at = 0;
        @(negedge clk);
        mv_valid = 1'b1; mv_p1 = 2'b01; mv_p2 = 2'b10;
        @(posedge clk);
        @(negedge clk);
        mv_valid = 1'b0;
        total++;
        if ({core_primo, core_secondo} !== 4'b0000) begin
            bad++; $display("FAIL lat_early got %b exp 0000", {core_primo, core_secondo});
        end
        @(negedge clk);
        total++;
        if ({core_primo, core_secondo} !== 4'b0110) begin
            bad++; $display("FAIL lat_pins got %b exp 0110", {core_primo, core_secondo});
        end
        @(negedge clk);
        tx_p1[0] = 2'b01; tx_p2[0] = 2'b10;
        model(1);
        check_score("latency");
    endtask

    task automatic test_empty;
        repeat (4) @(negedge clk);
        total++;
        if ({core_primo, core_secondo} !== 4'b0000) begin
            bad++; $display("FAIL empty_pins got %b exp 0000", {core_primo, core_secondo});
        end
        check_score("empty");
    endtask

    task automatic test_abort;
        int         d0;
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        d0 = done_cnt;
        do_start(c);
        total++;
        if ({core_reset, core_primo, core_secondo, result} !== {1'b1, c, 2'b00}) begin
            bad++; $display("FAIL abort_config got %b exp %b",
                            {core_reset, core_primo, core_secondo, result}, {1'b1, c, 2'b00});
        end
        model(0);
        check_score("abort");
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt !== d0) begin
            bad++; $display("FAIL abort_done got %0d pulses exp 0", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        do_start(4'($urandom_range(0, 15)));
        @(negedge clk);
        end_at = 0;
        for (int i = 0; i < 5; i++) begin
            tx_p1[i] = 2'($urandom_range(1, 3));
            tx_p2[i] = 2'($urandom_range(1, 3));
        end
        base = seen_p1.size();
        stream(5, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if (seen_p1.size() - base !== 5 || acc_n !== 5) begin
            bad++; $display("FAIL b2b_count got %0d exp 5", seen_p1.size() - base);
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (seen_p1[base+i] !== tx_p1[i] || seen_p2[base+i] !== tx_p2[i] ||
                    seen_cyc[base+i] !== seen_cyc[base] + i) begin
                    bad++; $display("FAIL b2b_pair%0d got %b%b @%0d exp %b%b @%0d", i,
                                    seen_p1[base+i], seen_p2[base+i], seen_cyc[base+i],
                                    tx_p1[i], tx_p2[i], seen_cyc[base] + i);
                end
            end
        end
        model(5);
        check_score("b2b");
    endtask

    task automatic test_match(input int n, input int e_at, input logic [1:0] ev,
                              input bit gaps, input string tag);
        int base, d0, guard;
        do_start(4'($urandom_range(0, 15)));
        @(negedge clk);
        end_at = e_at;
        end_val = ev;
        base = seen_p1.size();
        d0 = done_cnt;
        stream(n, gaps);
        guard = 0;
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL %s timeout busy got %b exp 0", tag, busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (seen_p1.size() - base !== e_at) begin
            bad++; $display("FAIL %s presented got %0d exp %0d", tag, seen_p1.size() - base, e_at);
        end else begin
            for (int i = 0; i < e_at; i++) begin
                total++;
                if (seen_p1[base+i] !== tx_p1[i] || seen_p2[base+i] !== tx_p2[i]) begin
                    bad++; $display("FAIL %s pair%0d got %b%b exp %b%b", tag, i,
                                    seen_p1[base+i], seen_p2[base+i], tx_p1[i], tx_p2[i]);
                end
            end
        end
        total++;
        if (result !== ev || done_cnt - d0 !== 1) begin
            bad++; $display("FAIL %s end got result=%b pulses=%0d exp result=%b pulses=1",
                            tag, result, done_cnt - d0, ev);
        end
        total++;
        if ({core_reset, core_primo, core_secondo, mv_ready, done} !== 7'b1_00_00_00) begin
            bad++; $display("FAIL %s idle got %b exp 1000000", tag,
                            {core_reset, core_primo, core_secondo, mv_ready, done});
        end
        model(e_at);
        check_score(tag);
    endtask

    task automatic test_start_collide;
        int         d0;
        logic [3:0] c;
        do_start(4'b0101);
        @(negedge clk);
        end_at = 1;
        end_val = 2'b01;
        d0 = done_cnt;
        mv_valid = 1'b1; mv_p1 = 2'b10; mv_p2 = 2'b01;
        @(posedge clk);
        @(negedge clk);
        mv_valid = 1'b0;
        @(negedge clk);
        c = 4'($urandom_range(0, 15));
        start = 1'b1;
        cfg_max = c;
        @(negedge clk);
        start = 1'b0;
        end_at = 0;
        total++;
        if ({core_reset, core_primo, core_secondo, busy, result} !== {1'b1, c, 1'b1, 2'b00}) begin
            bad++; $display("FAIL collide_config got %b exp %b",
                            {core_reset, core_primo, core_secondo, busy, result}, {1'b1, c, 1'b1, 2'b00});
        end
        model(0);
        check_score("collide");
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt !== d0) begin
            bad++; $display("FAIL collide_done got %0d pulses exp 0", done_cnt - d0);
        end
    endtask

    task automatic test_saturation;
        do_start(4'b1111);
        @(negedge clk);
        end_at = 0;
        for (int i = 0; i < 34; i++) begin
            tx_p1[i] = 2'($urandom_range(1, 3));
            tx_p2[i] = tx_p1[i];
        end
        tx_p1[33] = 2'b00;
        stream(34, 1'b0);
        repeat (3) @(negedge clk);
        model(34);
        check_score("saturation");
    endtask

    task automatic test_random(input int iters);
        int n;
        for (int it = 0; it < iters; it++) begin
            n = $urandom_range(3, 12);
            for (int i = 0; i < n; i++) begin
                tx_p2[i] = 2'($urandom_range(1, 3));
                tx_p1[i] = 2'($urandom_range(0, 3));
            end
            test_match(n, $urandom_range(1, n), 2'($urandom_range(1, 3)), 1'b1, "random");
        end
    endtask

    task automatic test_async_reset;
        do_start(4'b0011);
        @(negedge clk);
        end_at = 0;
        tx_p1[0] = 2'b11; tx_p2[0] = 2'b10;
        stream(1, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({core_reset, core_primo, core_secondo, busy, mv_ready} !== 7'b1_00_00_00) begin
            bad++; $display("FAIL areset_pins got %b exp 1000000",
                            {core_reset, core_primo, core_secondo, busy, mv_ready});
        end
        model(0);
        check_score("areset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_config(4'b0000);
        test_config(4'b1111);
        test_latency();
        test_empty();
        test_abort();
        test_back_to_back();
        for (int i = 0; i < 5; i++) begin
            tx_p1[i] = 2'($urandom_range(1, 3));
            tx_p2[i] = 2'($urandom_range(1, 3));
        end
        test_match(5, 3, 2'b10, 1'b0, "end_flush");
        test_start_collide();
        test_saturation();
        test_random(6);
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
